// File: rtl/simple_cnn.sv
// simple_cnn: 5x5 image, 3x3 valid convolution with a selectable kernel, ReLU,
// then a sequential arg-max/arg-min over the 9 features, one feature per cycle.
module simple_cnn #(
  parameter int PIX_W = 8,
  parameter int IMG_N = 5,
  parameter int K_N = 3
) (
  input  logic                             CLK,
  input  logic                             nRST,
  input  logic                             START,
  input  logic                             X,
  input  logic                             Y,
  input  logic [PIX_W*IMG_N*IMG_N-1:0]     IMGIN,
  output logic                             DONE,
  output logic [3:0]                       OUT
);
  localparam logic [1:0] IDLE = 2'd0, CONV = 2'd1, FIN = 2'd2;
  logic [1:0] state, row, col;
  logic [PIX_W*IMG_N*IMG_N-1:0] img;
  logic xs, ys, better;
  logic [3:0] idx, best_idx;
  logic signed [12:0] best, f, g, p, w;
  // Window origin from idx, then one full 3x3 dot product per cycle.
  always_comb begin
    row = idx >= 4'd6 ? 2'd2 : idx >= 4'd3 ? 2'd1 : 2'd0;
    col = 2'(idx - 4'(row) * 4'd3);
    f = '0;
    p = '0;
    w = '0;
    for (int a = 0; a < K_N; a++)
      for (int b = 0; b < K_N; b++) begin
        p = 13'(img[PIX_W*(IMG_N*(int'(row)+a)+int'(col)+b) +: PIX_W]);
        w = xs ? 13'sd1 : (a == 1 && b == 1) ? 13'sd4 : ((a + b) % 2 == 1) ? -13'sd1 : 13'sd0;
        f = f + w * p;
      end
    g = f < 0 ? '0 : f;
    better = idx == 4'd0 || (ys ? g < best : g > best);
  end
  always_ff @(posedge CLK or posedge nRST)
    if (nRST) begin
      state <= IDLE;
      img <= '0;
      xs <= 1'b0;
      ys <= 1'b0;
      idx <= '0;
      best <= '0;
      best_idx <= '0;
      DONE <= 1'b0;
      OUT <= '0;
    end else if (state == IDLE) begin
      if (START) begin
        img <= IMGIN;
        xs <= X;
        ys <= Y;
        idx <= '0;
        best <= '0;
        best_idx <= '0;
        state <= CONV;
      end
    end else if (state == CONV) begin
      best <= better ? g : best;
      best_idx <= better ? idx : best_idx;
      idx <= idx == 4'd8 ? 4'd0 : idx + 4'd1;
      if (idx == 4'd8) begin
        OUT <= better ? idx : best_idx;
        DONE <= 1'b1;
        state <= FIN;
      end
    end else begin
      DONE <= 1'b0;
      state <= IDLE;
    end
endmodule

// File: tb/tb_simple_cnn.sv
// tb_simple_cnn: directed + random vectors against a plain-arithmetic reference model.
module tb_simple_cnn;
  logic CLK = 1'b0, nRST = 1'b1, START = 1'b0, X = 1'b0, Y = 1'b0;
  logic [199:0] IMGIN = '0;
  logic DONE;
  logic [3:0] OUT;
  int checks = 0, errors = 0;
  int k0 [3][3] = '{'{0, -1, 0}, '{-1, 4, -1}, '{0, -1, 0}};

  typedef struct {
    logic [199:0] img;
    bit x;
    bit y;
    int exp_out;
    string name;
  } vec_t;
  vec_t vecs[$];

  simple_cnn dut (.CLK(CLK), .nRST(nRST), .START(START), .X(X), .Y(Y),
                  .IMGIN(IMGIN), .DONE(DONE), .OUT(OUT));

  always #5 CLK = ~CLK;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int model(logic [199:0] img, bit x, bit y);
    int gv[9];
    int s, best;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        s = 0;
        for (int a = 0; a < 3; a++)
          for (int b = 0; b < 3; b++)
            s += (x ? 1 : k0[a][b]) * int'(img[8*(5*(i+a)+j+b) +: 8]);
        gv[3*i+j] = s < 0 ? 0 : s;
      end
    best = 0;
    for (int n = 1; n < 9; n++)
      if (y ? gv[n] < gv[best] : gv[n] > gv[best]) best = n;
    return best;
  endfunction

  function automatic logic [199:0] one_pix(int r, int c, int v);
    logic [199:0] im = '0;
    im[8*(5*r+c) +: 8] = 8'(v);
    return im;
  endfunction

  function automatic logic [199:0] rand_img(int maxv);
    logic [199:0] im;
    for (int n = 0; n < 25; n++) im[8*n +: 8] = 8'($urandom_range(0, maxv));
    return im;
  endfunction

  task automatic run_vec(vec_t v, bit disturb);
    bit early = 0;
    X = v.x;
    Y = v.y;
    IMGIN = v.img;
    START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      if (disturb && k >= 2 && k <= 5) begin
        X = ~X;
        Y = ~Y;
        IMGIN = rand_img(255);
      end
      START = disturb && k == 3;
      @(posedge CLK);
      #1;
      if (k < 9 && DONE) early = 1;
    end
    chk({v.name, " done_early"}, 32'(early), 0);
    chk({v.name, " done_at_e9"}, 32'(DONE), 1);
    chk({v.name, " out"}, 32'(OUT), 32'(v.exp_out));
    @(posedge CLK);
    #1;
    chk({v.name, " done_drop"}, 32'(DONE), 0);
    chk({v.name, " out_hold"}, 32'(OUT), 32'(v.exp_out));
    repeat (2) @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [199:0] ramp;
    vec_t v;
    bit seen;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) ramp[8*(5*r+c) +: 8] = 8'(5*r + c);
    vecs.push_back('{'0, 1'b0, 1'b0, 0, "zero"});
    vecs.push_back('{one_pix(2, 2, 255), 1'b0, 1'b0, 4, "center_edge"});
    vecs.push_back('{one_pix(0, 0, 255), 1'b1, 1'b0, 0, "corner_max"});
    vecs.push_back('{one_pix(0, 0, 255), 1'b1, 1'b1, 1, "corner_min"});
    vecs.push_back('{ramp, 1'b1, 1'b0, 8, "ramp"});
    for (int n = 0; n < 12; n++) begin
      v.img = rand_img(n % 2 ? 255 : 3);
      v.x = 1'($urandom);
      v.y = 1'($urandom);
      v.exp_out = model(v.img, v.x, v.y);
      v.name = $sformatf("rand%0d", n);
      vecs.push_back(v);
    end

    repeat (2) @(posedge CLK);
    #1;
    nRST = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge CLK);
      #1;
      chk("idle_done", 32'(DONE), 0);
      chk("idle_out", 32'(OUT), 0);
    end

    foreach (vecs[n]) run_vec(vecs[n], 1'b0);
    foreach (vecs[n]) if (n % 3 == 0) run_vec(vecs[n], 1'b1);

    run_vec(vecs[4], 1'b0);
    X = 1'b1;
    Y = 1'b0;
    IMGIN = ramp;
    START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    nRST = 1'b1;
    #1;
    chk("abort_out", 32'(OUT), 0);
    chk("abort_done", 32'(DONE), 0);
    @(posedge CLK);
    #1;
    nRST = 1'b0;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge CLK);
      #1;
      if (DONE) seen = 1;
    end
    chk("abort_no_done", 32'(seen), 0);
    chk("abort_out_held", 32'(OUT), 0);
    run_vec(vecs[1], 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
